nrs_qpsk_mapper_tx: RTL and testbench



---
 rtl/nrs_pkg.sv | 20 ++
 rtl/nrs_bit2qpsk.sv | 17 +
 rtl/nrs_qpsk_mapper_tx.sv | 147 ++++++++++++++
 tb/tb_nrs_qpsk_mapper_tx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/nrs_pkg.sv
// rtl/nrs_pkg.sv - shared constants, FSM states and amplitude helper for the NRS pilot generator
package nrs_pkg;

  localparam logic [15:0] NRS_AMP_Q511 = 16'h05A8;
  localparam int          NRB_MAX      = 110;
  localparam int          NRS_DISCARD  = 2 * (NRB_MAX - 1);

  typedef enum logic [1:0] {
    IDLE,
    DISCARD,
    COLLECT,
    OUTPUT
  } nrs_state_t;

  // 0 -> +AMP, 1 -> -AMP (exact two's complement) at the default 16-bit width
  function automatic logic [15:0] nrs_bit2amp(input logic b);
    return b ? (~NRS_AMP_Q511 + 16'd1) : NRS_AMP_Q511;
  endfunction

endpackage

// File: rtl/nrs_bit2qpsk.sv
// rtl/nrs_bit2qpsk.sv - combinational QPSK decision: bit pair to {re, im} of +/-AMP
module nrs_bit2qpsk #(
  parameter int                 W   = 16,
  parameter logic [W-1:0]       AMP = 16'h05A8
) (
  input  logic [1:0]   bits,
  output logic [W-1:0] re,
  output logic [W-1:0] im
);

  localparam logic [W-1:0] NEG_AMP = ~AMP + 1'b1;

  // bits[0] is c(2m) driving the real part, bits[1] is c(2m+1) driving the imaginary part
  assign re = bits[0] ? NEG_AMP : AMP;
  assign im = bits[1] ? NEG_AMP : AMP;

endmodule

// File: rtl/nrs_qpsk_mapper_tx.sv
// rtl/nrs_qpsk_mapper_tx.sv - NB-IoT NRS pilot generator: drops leading Gold bits,
// collects 2 bits per pilot and streams QPSK pilots to the RE mapper
module nrs_qpsk_mapper_tx
  import nrs_pkg::*;
#(
  parameter int                           NRS_WIDTH_R_I = 16,
  parameter logic [NRS_WIDTH_R_I-1:0]     AMP           = NRS_WIDTH_R_I'(NRS_AMP_Q511),
  parameter int                           NUM_PILOTS    = 2,
  parameter int                           DISCARD_BITS  = NRS_DISCARD
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              gold_bit,
  input  logic                              gold_valid,
  output logic                              gold_ready,
  output logic [NRS_WIDTH_R_I-1:0]          nrs_r,
  output logic [NRS_WIDTH_R_I-1:0]          nrs_i,
  output logic [$clog2(NUM_PILOTS):0]       nrs_idx,
  output logic                              nrs_last,
  output logic                              nrs_valid,
  input  logic                              nrs_ready,
  output logic                              done
);

  localparam int BW = 2 * NUM_PILOTS;
  localparam int DW = (DISCARD_BITS > 0) ? $clog2(DISCARD_BITS + 1) : 1;
  localparam int CW = $clog2(BW + 1);
  localparam int IW = $clog2(NUM_PILOTS) + 1;
  localparam nrs_state_t START_ST = (DISCARD_BITS == 0) ? COLLECT : DISCARD;

  nrs_state_t              state, state_nxt;
  logic [DW-1:0]           disc_cnt;
  logic [CW-1:0]           col_cnt;
  logic [BW-1:0]           bbuf;
  logic [BW-1:0]           bbuf_shift;
  logic [1:0]              pair;
  logic [NRS_WIDTH_R_I-1:0] map_r, map_i;
  logic [IW-1:0]           idx_nxt;
  logic                    bit_xfer, pil_xfer, disc_last, col_last;

  assign bit_xfer   = gold_valid && gold_ready;
  assign pil_xfer   = nrs_valid && nrs_ready;
  assign disc_last  = (disc_cnt == DW'(DISCARD_BITS - 1));
  assign col_last   = (col_cnt == CW'(BW - 1));
  assign idx_nxt    = nrs_idx + 1'b1;
  // new bits enter at the top so that after BW shifts bit k sits at position k
  assign bbuf_shift = {gold_bit, bbuf[BW-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = START_ST;
    end else begin
      case (state)
        DISCARD: if (bit_xfer && disc_last)  state_nxt = COLLECT;
        COLLECT: if (bit_xfer && col_last)   state_nxt = OUTPUT;
        OUTPUT:  if (pil_xfer && nrs_last)   state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    gold_ready = 1'b0;
    case (state)
      DISCARD, COLLECT: gold_ready = 1'b1;
      default:          gold_ready = 1'b0;
    endcase
  end

  // pilot 0 comes straight from the completing shift; later pilots from the drained buffer
  always_comb begin
    pair = bbuf[1:0];
    if (state == COLLECT) pair = bbuf_shift[1:0];
  end

  nrs_bit2qpsk #(
    .W   (NRS_WIDTH_R_I),
    .AMP (AMP)
  ) u_bit2qpsk (
    .bits (pair),
    .re   (map_r),
    .im   (map_i)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disc_cnt  <= '0;
      col_cnt   <= '0;
      bbuf      <= '0;
      nrs_r     <= '0;
      nrs_i     <= '0;
      nrs_idx   <= '0;
      nrs_last  <= 1'b0;
      nrs_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        disc_cnt  <= '0;
        col_cnt   <= '0;
        bbuf      <= '0;
        nrs_idx   <= '0;
        nrs_last  <= 1'b0;
        nrs_valid <= 1'b0;
      end else begin
        case (state)
          DISCARD: if (bit_xfer) disc_cnt <= disc_cnt + 1'b1;
          COLLECT: if (bit_xfer) begin
            col_cnt <= col_cnt + 1'b1;
            if (col_last) begin
              bbuf      <= bbuf_shift >> 2;
              nrs_r     <= map_r;
              nrs_i     <= map_i;
              nrs_idx   <= '0;
              nrs_last  <= (NUM_PILOTS == 1);
              nrs_valid <= 1'b1;
            end else begin
              bbuf <= bbuf_shift;
            end
          end
          OUTPUT: if (pil_xfer) begin
            if (nrs_last) begin
              nrs_valid <= 1'b0;
              nrs_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              bbuf     <= bbuf >> 2;
              nrs_r    <= map_r;
              nrs_i    <= map_i;
              nrs_idx  <= idx_nxt;
              nrs_last <= (idx_nxt == IW'(NUM_PILOTS - 1));
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nrs_qpsk_mapper_tx.sv
// tb/tb_nrs_qpsk_mapper_tx.sv - directed self-checking bench for nrs_qpsk_mapper_tx
module tb_nrs_qpsk_mapper_tx;

  localparam logic [15:0] P = 16'h05A8;
  localparam logic [15:0] N = 16'hFA58;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s0 = 0, g0_bit = 0, g0_valid = 0, g0_ready, r0_ready = 0, v0, l0, d0;
  logic [15:0] r0, i0;
  logic [1:0]  x0;
  logic        s1 = 0, g1_bit = 0, g1_valid = 0, g1_ready, r1_ready = 0, v1, l1, d1;
  logic [15:0] r1, i1;
  logic [2:0]  x1;

  int checks = 0;
  int errors = 0;

  nrs_qpsk_mapper_tx #(.NUM_PILOTS(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(s0), .gold_bit(g0_bit), .gold_valid(g0_valid),
    .gold_ready(g0_ready), .nrs_r(r0), .nrs_i(i0), .nrs_idx(x0), .nrs_last(l0),
    .nrs_valid(v0), .nrs_ready(r0_ready), .done(d0)
  );

  nrs_qpsk_mapper_tx #(.NUM_PILOTS(4), .DISCARD_BITS(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .gold_bit(g1_bit), .gold_valid(g1_valid),
    .gold_ready(g1_ready), .nrs_r(r1), .nrs_i(i1), .nrs_idx(x1), .nrs_last(l1),
    .nrs_valid(v1), .nrs_ready(r1_ready), .done(d1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pilot(input string tag, input logic v, input logic [15:0] r, input logic [15:0] i,
                           input int idx, input logic last,
                           input logic [15:0] er, input logic [15:0] ei, input int eidx, input logic elast);
    chk({tag, "_valid"}, 32'(v), 32'd1);
    chk({tag, "_r"}, 32'(r), 32'(er));
    chk({tag, "_i"}, 32'(i), 32'(ei));
    chk({tag, "_idx"}, 32'(idx), 32'(eidx));
    chk({tag, "_last"}, 32'(last), 32'(elast));
  endtask

  task automatic push0(input logic b, input bit gap);
    int n;
    n = 0;
    if (gap) begin
      g0_valid = 1'b0;
      g0_bit   = ~b;
      tick();
    end
    g0_bit   = b;
    g0_valid = 1'b1;
    while (!g0_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("push0_ready_timeout", 32'(g0_ready), 32'd1);
    tick();
    g0_valid = 1'b0;
  endtask

  task automatic push1(input logic b);
    int n;
    n = 0;
    g1_bit   = b;
    g1_valid = 1'b1;
    while (!g1_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("push1_ready_timeout", 32'(g1_ready), 32'd1);
    tick();
    g1_valid = 1'b0;
  endtask

  task automatic start0();
    s0 = 1'b1;
    tick();
    s0 = 1'b0;
  endtask

  task automatic discard0(input bit gap, input bit ones);
    for (int k = 0; k < 218; k++) push0(ones ? 1'b1 : 1'($urandom_range(0, 1)), gap);
  endtask

  logic [7:0] pat1;

  initial begin
    // reset state
    tick();
    chk("rst_gold_ready", 32'(g0_ready), 32'd0);
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_r", 32'(r0), 32'd0);
    chk("rst_i", 32'(i0), 32'd0);
    chk("rst_idx", 32'(x0), 32'd0);
    chk("rst_last", 32'(l0), 32'd0);
    chk("rst_done", 32'(d0), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_gold_ready", 32'(g0_ready), 32'd0);

    // basic symbol, downstream always ready
    start0();
    chk("discard_gold_ready", 32'(g0_ready), 32'd1);
    r0_ready = 1'b1;
    discard0(1'b0, 1'b0);
    push0(1, 0); push0(0, 0); push0(0, 0); push0(1, 0);
    chk_pilot("t1_p0", v0, r0, i0, int'(x0), l0, N, P, 0, 1'b0);
    chk("t1_output_gold_ready", 32'(g0_ready), 32'd0);
    chk("t1_p0_done", 32'(d0), 32'd0);
    tick();
    chk_pilot("t1_p1", v0, r0, i0, int'(x0), l0, P, N, 1, 1'b1);
    chk("t1_p1_done", 32'(d0), 32'd0);
    tick();
    chk("t1_valid_after", 32'(v0), 32'd0);
    chk("t1_done", 32'(d0), 32'd1);
    tick();
    chk("t1_done_pulse", 32'(d0), 32'd0);
    chk("t1_idle_gold_ready", 32'(g0_ready), 32'd0);

    // backpressure at pilot 0
    r0_ready = 1'b0;
    start0();
    discard0(1'b0, 1'b0);
    push0(1, 0); push0(0, 0); push0(0, 0); push0(1, 0);
    for (int k = 0; k < 5; k++) begin
      chk_pilot("t2_hold", v0, r0, i0, int'(x0), l0, N, P, 0, 1'b0);
      tick();
    end
    chk_pilot("t2_hold_end", v0, r0, i0, int'(x0), l0, N, P, 0, 1'b0);
    r0_ready = 1'b1;
    tick();
    chk_pilot("t2_p1", v0, r0, i0, int'(x0), l0, P, N, 1, 1'b1);
    tick();
    chk("t2_done", 32'(d0), 32'd1);

    // 50% gold_valid duty, discard bits all 1 so a miscount corrupts the pilots
    start0();
    discard0(1'b1, 1'b1);
    push0(0, 1); push0(1, 1); push0(1, 1); push0(0, 1);
    chk_pilot("t3_p0", v0, r0, i0, int'(x0), l0, P, N, 0, 1'b0);
    chk("t3_output_gold_ready", 32'(g0_ready), 32'd0);
    tick();
    chk_pilot("t3_p1", v0, r0, i0, int'(x0), l0, N, P, 1, 1'b1);
    tick();
    chk("t3_done", 32'(d0), 32'd1);

    // abort during COLLECT, start beats a simultaneous bit transfer
    start0();
    discard0(1'b0, 1'b0);
    push0(1, 0); push0(1, 0);
    s0 = 1'b1; g0_valid = 1'b1; g0_bit = 1'b1;
    tick();
    s0 = 1'b0; g0_valid = 1'b0;
    chk("t4_abort_valid", 32'(v0), 32'd0);
    chk("t4_abort_done", 32'(d0), 32'd0);
    chk("t4_abort_gold_ready", 32'(g0_ready), 32'd1);
    discard0(1'b0, 1'b0);
    push0(0, 0); push0(0, 0); push0(1, 0); push0(1, 0);
    chk("t4_no_early_done", 32'(d0), 32'd0);
    chk_pilot("t4_p0", v0, r0, i0, int'(x0), l0, P, P, 0, 1'b0);
    tick();
    chk_pilot("t4_p1", v0, r0, i0, int'(x0), l0, N, N, 1, 1'b1);
    tick();
    chk("t4_done", 32'(d0), 32'd1);

    // asynchronous reset while a pilot is pending
    r0_ready = 1'b0;
    start0();
    discard0(1'b0, 1'b0);
    push0(1, 0); push0(1, 0); push0(1, 0); push0(1, 0);
    chk("t5_valid_before", 32'(v0), 32'd1);
    chk("t5_r_before", 32'(r0), 32'(N));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(v0), 32'd0);
    chk("t5_async_r", 32'(r0), 32'd0);
    chk("t5_async_i", 32'(i0), 32'd0);
    chk("t5_async_gold_ready", 32'(g0_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("t5_idle_gold_ready", 32'(g0_ready), 32'd0);
    chk("t5_idle_valid", 32'(v0), 32'd0);

    // NUM_PILOTS=4, no discard: straight to COLLECT
    s1 = 1'b1;
    tick();
    s1 = 1'b0;
    chk("t6_collect_gold_ready", 32'(g1_ready), 32'd1);
    r1_ready = 1'b1;
    pat1 = 8'b1100_1001;
    for (int k = 7; k >= 0; k--) push1(pat1[k]);
    chk_pilot("t6_p0", v1, r1, i1, int'(x1), l1, N, N, 0, 1'b0);
    tick();
    chk_pilot("t6_p1", v1, r1, i1, int'(x1), l1, P, P, 1, 1'b0);
    tick();
    chk_pilot("t6_p2", v1, r1, i1, int'(x1), l1, N, P, 2, 1'b0);
    tick();
    chk_pilot("t6_p3", v1, r1, i1, int'(x1), l1, P, N, 3, 1'b1);
    tick();
    chk("t6_valid_after", 32'(v1), 32'd0);
    chk("t6_done", 32'(d1), 32'd1);
    chk("t6_idle_gold_ready", 32'(g1_ready), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
